// File: rtl/hba_reset_seq.sv
// hba_reset_seq: power-on / PLL-lock reset sequencer.
// Waits for a filtered, synchronized PLL lock. It then holds every channel in reset
// for HOLD_CYCLES and releases the channels one at a time, STAGGER_CYCLES apart.
// Lock loss sends the block back to WAIT_LOCK and is counted. A soft request restarts
// the sequence from HOLD.
// Ports:
//   clk             system clock (PLL output)
//   reset           asynchronous active-low reset
//   pll_locked      raw PLL lock, asynchronous to clk
//   soft_reset_req  synchronous restart request (HOLD/RELEASE/RUN only)
//   rst_out         active-high channel resets, bit 0 released first
//   all_released    every rst_out bit is low
//   seq_state       0=WAIT_LOCK 1=HOLD 2=RELEASE 3=RUN
//   lock_lost_count saturating count of lock-loss events
module hba_reset_seq #(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned LOCK_FILTER    = 8,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pll_locked,
    input  logic                    soft_reset_req,
    output logic [NUM_CHANNELS-1:0] rst_out,
    output logic                    all_released,
    output logic [1:0]              seq_state,
    output logic [7:0]              lock_lost_count
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] FILTER_LAST = CNT_WIDTH'(LOCK_FILTER - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAG_LAST   =
        CNT_WIDTH'((STAGGER_CYCLES == 0) ? 0 : STAGGER_CYCLES - 1);
    localparam logic [NUM_CHANNELS-1:0] ALL_ONES      = '1;
    localparam logic [NUM_CHANNELS-1:0] FIRST_RELEASE = ALL_ONES << 1;
    // With no stagger, or a single channel, leaving HOLD releases everything at once.
    localparam bit RELEASE_AT_ONCE = (STAGGER_CYCLES == 0) || (NUM_CHANNELS == 1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                    all_released_q, all_released_d;
    logic [7:0]              lost_q, lost_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    locked_s;

    assign locked_s = sync2_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rst_out_d      = rst_out_q;
        all_released_d = all_released_q;
        lost_d         = lost_q;
        sync1_d        = pll_locked;
        sync2_d        = sync1_q;

        if (state_q == ST_WAIT_LOCK) begin
            // Any low sample restarts the lock filter; soft requests are ignored here.
            if (locked_s) begin
                if (cnt_q == FILTER_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else if (!locked_s) begin
            // Lock loss takes priority over a simultaneous soft request.
            state_d        = ST_WAIT_LOCK;
            cnt_d          = '0;
            rst_out_d      = ALL_ONES;
            all_released_d = 1'b0;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end else if (soft_reset_req) begin
            state_d        = ST_HOLD;
            cnt_d          = '0;
            rst_out_d      = ALL_ONES;
            all_released_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (RELEASE_AT_ONCE) begin
                            state_d        = ST_RUN;
                            rst_out_d      = '0;
                            all_released_d = 1'b1;
                        end else begin
                            state_d   = ST_RELEASE;
                            rst_out_d = FIRST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    // rst_out_q is a run of ones above the released bits; shifting
                    // left by one releases the next channel in order.
                    if (cnt_q == STAG_LAST) begin
                        cnt_d     = '0;
                        rst_out_d = rst_out_q << 1;
                        if ((rst_out_q << 1) == '0) begin
                            state_d        = ST_RUN;
                            all_released_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            rst_out_q      <= ALL_ONES;
            all_released_q <= 1'b0;
            lost_q         <= 8'd0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rst_out_q      <= rst_out_d;
            all_released_q <= all_released_d;
            lost_q         <= lost_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
        end
    end

    assign rst_out         = rst_out_q;
    assign all_released    = all_released_q;
    assign seq_state       = state_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_hba_reset_seq.sv
// Testbench for hba_reset_seq: two instances share the same stimulus.
// Instance 0 uses the default parameters. Instance 1 has 8 channels and no stagger.
module tb_hba_reset_seq;

    localparam int unsigned N0   = 4;
    localparam int unsigned N1   = 8;
    localparam int unsigned S0   = 4;
    localparam int unsigned S1   = 0;
    localparam int unsigned HOLD = 10;
    localparam int unsigned LF   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_locked;
    logic          soft_reset_req;
    logic [N0-1:0] rst0;
    logic [N1-1:0] rst1;
    logic          ar0, ar1;
    logic [1:0]    st0, st1;
    logic [7:0]    ll0, ll1;

    always #5 clk = ~clk;

    hba_reset_seq #(.NUM_CHANNELS(N0), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(S0),
                    .LOCK_FILTER(LF), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
        .rst_out(rst0), .all_released(ar0), .seq_state(st0), .lock_lost_count(ll0));

    hba_reset_seq #(.NUM_CHANNELS(N1), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(S1),
                    .LOCK_FILTER(LF), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
        .rst_out(rst1), .all_released(ar1), .seq_state(st1), .lock_lost_count(ll1));

    typedef struct packed {
        logic [7:0] rst;
        logic       ar;
        logic [1:0] st;
        logic [7:0] ll;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    bit   done = 1'b0;

    // Reference model: phase, consecutive lock samples, time in phase, loss count.
    int m_ph[2];
    int m_run[2];
    int m_t[2];
    int m_lost[2];
    int pl_d1 = 0;
    int pl_d2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel i is held until i*stag cycles after the release phase begins.
    function automatic logic [7:0] rst_vec(input int n, input int stag, input int ph, input int t);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (ph < 2) v[i] = 1'b1;
            else if (ph == 2 && t < i * stag) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_update(input int idx, input int ls);
        int n;
        int stag;
        n    = (idx == 0) ? N0 : N1;
        stag = (idx == 0) ? S0 : S1;
        if (m_ph[idx] == 0) begin
            if (ls != 0) begin
                m_run[idx]++;
                if (m_run[idx] == LF) begin
                    m_ph[idx] = 1;
                    m_t[idx]  = 0;
                end
            end else begin
                m_run[idx] = 0;
            end
        end else if (ls == 0) begin
            m_ph[idx]  = 0;
            m_run[idx] = 0;
            if (m_lost[idx] < 255) m_lost[idx]++;
        end else if (soft_reset_req) begin
            m_ph[idx] = 1;
            m_t[idx]  = 0;
        end else if (m_ph[idx] == 1) begin
            m_t[idx]++;
            if (m_t[idx] == HOLD) begin
                m_ph[idx] = 2;
                m_t[idx]  = 0;
            end
        end else if (m_ph[idx] == 2) begin
            m_t[idx]++;
        end
        if (m_ph[idx] == 2 && rst_vec(n, stag, 2, m_t[idx]) == 8'd0) m_ph[idx] = 3;
    endtask

    function automatic exp_t model_out(input int idx);
        exp_t e;
        e.rst = rst_vec((idx == 0) ? N0 : N1, (idx == 0) ? S0 : S1, m_ph[idx], m_t[idx]);
        e.ar  = (m_ph[idx] == 3);
        e.st  = 2'(m_ph[idx]);
        e.ll  = 8'(m_lost[idx]);
        return e;
    endfunction

    // Advance the model by one clock edge using the current inputs; queue the expectation.
    task automatic model_edge();
        int ls;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_run[i] = 0; m_t[i] = 0; m_lost[i] = 0;
            end
            pl_d1 = 0;
            pl_d2 = 0;
        end else begin
            ls    = pl_d2;
            pl_d2 = pl_d1;
            pl_d1 = pll_locked ? 1 : 0;
            model_update(0, ls);
            model_update(1, ls);
        end
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_rst0"}, 32'(rst0), 32'h0F);
        chk({tag, "_rst1"}, 32'(rst1), 32'hFF);
        chk({tag, "_st0"},  32'(st0),  32'd0);
        chk({tag, "_st1"},  32'(st1),  32'd0);
        chk({tag, "_ar0"},  32'(ar0),  32'd0);
        chk({tag, "_ll0"},  32'(ll0),  32'd0);
    endtask

    // Monitor: every cycle the outputs are compared with the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (q0.size() == 0) chk("sb0_empty", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("sb0", 32'({8'(rst0), ar0, st0, ll0}), 32'(e));
                end
                if (q1.size() == 0) chk("sb1_empty", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("sb1", 32'({rst1, ar1, st1, ll1}), 32'(e));
                end
            end
        end
    end

    initial begin
        int drop;
        reset          = 1'b0;
        pll_locked     = 1'b1;
        soft_reset_req = 1'b0;
        repeat (5) step();
        chk("reset_st0", 32'(st0), 32'd0);
        chk("reset_rst0", 32'(rst0), 32'h0F);

        // Bring-up with lock held high.
        reset = 1'b1;
        k     = 0;
        run_to(10);
        chk("hold_entry_st0", 32'(st0), 32'd1);
        chk("hold_entry_rst0", 32'(rst0), 32'h0F);
        run_to(19);
        chk("hold_last_st0", 32'(st0), 32'd1);
        run_to(20);
        chk("rel_first_st0", 32'(st0), 32'd2);
        chk("rel_first_rst0", 32'(rst0), 32'h0E);
        chk("nostag_rst1", 32'(rst1), 32'h00);
        chk("nostag_ar1", 32'(ar1), 32'd1);
        chk("nostag_st1", 32'(st1), 32'd3);
        run_to(23);
        chk("rel_r3_rst0", 32'(rst0), 32'h0E);
        run_to(24);
        chk("rel_r4_rst0", 32'(rst0), 32'h0C);
        run_to(31);
        chk("rel_r11_rst0", 32'(rst0), 32'h08);
        chk("rel_r11_ar0", 32'(ar0), 32'd0);
        run_to(32);
        chk("run_rst0", 32'(rst0), 32'h00);
        chk("run_ar0", 32'(ar0), 32'd1);
        chk("run_st0", 32'(st0), 32'd3);
        run_to(40);

        // Async reset in RUN, then a lock glitch during filtering.
        async_reset_check("arst_run");
        repeat (3) step();
        reset = 1'b1;
        k     = 0;
        run_to(5);
        pll_locked = 1'b0;
        run_to(6);
        pll_locked = 1'b1;
        run_to(10);
        chk("glitch_no_hold_early", 32'(st0), 32'd0);
        run_to(15);
        chk("glitch_still_wait", 32'(st0), 32'd0);
        run_to(16);
        chk("glitch_hold_entry", 32'(st0), 32'd1);

        // Lock loss in RUN.
        run_to(40);
        chk("pre_loss_st0", 32'(st0), 32'd3);
        pll_locked = 1'b0;
        run_to(41);
        pll_locked = 1'b1;
        run_to(42);
        chk("loss_lat_st0", 32'(st0), 32'd3);
        run_to(43);
        chk("loss_st0", 32'(st0), 32'd0);
        chk("loss_rst0", 32'(rst0), 32'h0F);
        chk("loss_ar0", 32'(ar0), 32'd0);
        chk("loss_ll0", 32'(ll0), 32'd1);
        chk("loss_ll1", 32'(ll1), 32'd1);

        // Soft request after channel 1 is released.
        run_to(65);
        chk("soft_pre_rst0", 32'(rst0), 32'h0C);
        soft_reset_req = 1'b1;
        run_to(66);
        soft_reset_req = 1'b0;
        chk("soft_st0", 32'(st0), 32'd1);
        chk("soft_rst0", 32'(rst0), 32'h0F);
        chk("soft_ll0", 32'(ll0), 32'd1);
        run_to(75);
        chk("soft_hold_end", 32'(st0), 32'd1);
        run_to(76);
        chk("soft_rel_st0", 32'(st0), 32'd2);
        chk("soft_rel_rst0", 32'(rst0), 32'h0E);

        // Lock loss and soft request on the same cycle in RUN.
        run_to(90);
        pll_locked = 1'b0;
        run_to(91);
        pll_locked = 1'b1;
        run_to(92);
        soft_reset_req = 1'b1;
        run_to(93);
        soft_reset_req = 1'b0;
        chk("both_st0", 32'(st0), 32'd0);
        chk("both_ll0", 32'(ll0), 32'd2);
        chk("both_st1", 32'(st1), 32'd0);
        chk("both_ll1", 32'(ll1), 32'd2);

        // Randomized lock drops and soft requests.
        drop = 0;
        for (int c = 0; c < 2000; c++) begin
            if (drop > 0) begin
                pll_locked = 1'b0;
                drop--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 39) == 0) drop = int'($urandom_range(1, 3));
            end
            soft_reset_req = ($urandom_range(0, 29) == 0);
            step();
        end
        soft_reset_req = 1'b0;

        // Repeated losses; each one lands while in HOLD.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            repeat (12) step();
        end
        chk("sat_ll0", 32'(ll0), 32'd255);
        chk("sat_ll1", 32'(ll1), 32'd255);
        chk("sat_in_hold", 32'(st0), 32'd1);

        // Async reset asserted mid-HOLD.
        async_reset_check("arst_hold");
        repeat (3) step();
        reset = 1'b1;
        repeat (40) step();

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
